// File: rtl/mcpu5_host_pkg.sv
// Shared opcodes and host FSM state encoding for the MCPU5 host driver.
// The opcode prefixes document the CPU instruction map the driver serves.
package mcpu5_host_pkg;

  localparam logic [5:0] OP_OUT = 6'b111011;
  localparam logic [5:0] OP_NOP = 6'b111111;
  localparam logic [1:0] OP_LDI = 2'b01;
  localparam logic [2:0] OP_STA = 3'b101;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [1:0] OP_BCC = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RESET  = 3'd1,
    ST_RUN_LO = 3'd2,
    ST_RUN_HI = 3'd3,
    ST_PAUSE  = 3'd4
  } host_state_t;

  function automatic logic is_out(input logic [5:0] inst);
    return inst == OP_OUT;
  endfunction

endpackage

// File: rtl/mcpu5_prog_mem.sv
// Program store: DEPTH x 6-bit register array, synchronous write, asynchronous read.
// Contents survive host reset so a program can be reloaded or reused after rst_n.
module mcpu5_prog_mem #(
  parameter int DEPTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [5:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [5:0]    rdata_o
);

  logic [5:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mcpu5_host_driver.sv
// Host-side MCPU5 driver: clocks and resets the CPU, serves instructions by PC,
// and captures the accumulator on OUT into a one-entry valid/ready buffer.
module mcpu5_host_driver
  import mcpu5_host_pkg::*;
#(
  parameter int DEPTH      = 32,
  parameter int HALF       = 2,
  parameter int RST_CYCLES = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          run,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [5:0]    prog_data,
  output logic          cpu_clk,
  output logic          cpu_rst,
  output logic [5:0]    cpu_inst,
  input  logic [7:0]    cpu_bus,
  output logic [7:0]    pc_mon,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          overflow
);

  localparam int PW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int RW = (2 * RST_CYCLES > 1) ? $clog2(2 * RST_CYCLES) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(HALF - 1);
  localparam logic [RW-1:0] RH_LAST = RW'(2 * RST_CYCLES - 1);

  host_state_t   state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [RW-1:0] hcnt_q, hcnt_d;
  logic          cpu_clk_q, cpu_clk_d;
  logic          cpu_rst_q, cpu_rst_d;
  logic [5:0]    cpu_inst_q, cpu_inst_d;
  logic [7:0]    pc_mon_q, pc_mon_d;
  logic [7:0]    out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          overflow_q, overflow_d;

  logic          phase_last;
  logic [PW-1:0] phase_inc;
  logic          capture;
  logic          mem_we;
  logic [AW-1:0] mem_raddr;
  logic [5:0]    mem_rdata;

  // Program loads are only safe while the CPU clock is stopped.
  assign mem_we    = prog_we && (state_q == ST_IDLE || state_q == ST_PAUSE);
  assign mem_raddr = (state_q == ST_RUN_HI) ? cpu_bus[AW-1:0] : '0;

  mcpu5_prog_mem #(
    .DEPTH(DEPTH)
  ) u_prog_mem (
    .clk_i   (clk),
    .we_i    (mem_we),
    .waddr_i (prog_addr),
    .wdata_i (prog_data),
    .raddr_i (mem_raddr),
    .rdata_o (mem_rdata)
  );

  assign phase_last = (phase_q == PH_LAST);
  assign phase_inc  = phase_last ? '0 : phase_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    hcnt_d     = hcnt_q;
    cpu_clk_d  = cpu_clk_q;
    cpu_rst_d  = cpu_rst_q;
    cpu_inst_d = cpu_inst_q;
    pc_mon_d   = pc_mon_q;
    capture    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cpu_clk_d  = 1'b0;
        cpu_rst_d  = 1'b1;
        cpu_inst_d = '0;
      end
      ST_RESET: begin
        phase_d = phase_inc;
        if (phase_last) begin
          cpu_clk_d = ~cpu_clk_q;
          hcnt_d    = hcnt_q + 1'b1;
          if (hcnt_q == RH_LAST) begin
            state_d    = ST_RUN_LO;
            hcnt_d     = '0;
            cpu_clk_d  = 1'b0;
            cpu_rst_d  = 1'b0;
            cpu_inst_d = mem_rdata;
          end
        end
      end
      ST_RUN_LO: begin
        phase_d = phase_inc;
        if (phase_last) begin
          if (run) begin
            state_d   = ST_RUN_HI;
            cpu_clk_d = 1'b1;
            // Capture only when the rising edge will actually execute OUT,
            // so a pause/resume on an OUT does not emit it twice.
            capture   = is_out(cpu_inst_q);
          end else begin
            state_d = ST_PAUSE;
          end
        end
      end
      ST_RUN_HI: begin
        phase_d = phase_inc;
        if (phase_last) begin
          state_d    = ST_RUN_LO;
          cpu_clk_d  = 1'b0;
          pc_mon_d   = cpu_bus;
          cpu_inst_d = mem_rdata;
        end
      end
      ST_PAUSE: begin
        if (run) begin
          state_d = ST_RUN_LO;
          phase_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (start) begin
      state_d    = ST_RESET;
      phase_d    = '0;
      hcnt_d     = '0;
      cpu_clk_d  = 1'b0;
      cpu_rst_d  = 1'b1;
      cpu_inst_d = '0;
      capture    = 1'b0;
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    overflow_d  = overflow_q;
    if (capture) begin
      if (!out_valid_q || out_ready) begin
        out_data_d  = cpu_bus;
        out_valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (out_ready && out_valid_q) begin
      out_valid_d = 1'b0;
    end
    if (start) begin
      out_valid_d = 1'b0;
      overflow_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      hcnt_q      <= '0;
      cpu_clk_q   <= 1'b0;
      cpu_rst_q   <= 1'b1;
      cpu_inst_q  <= '0;
      pc_mon_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      hcnt_q      <= hcnt_d;
      cpu_clk_q   <= cpu_clk_d;
      cpu_rst_q   <= cpu_rst_d;
      cpu_inst_q  <= cpu_inst_d;
      pc_mon_q    <= pc_mon_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  assign cpu_clk   = cpu_clk_q;
  assign cpu_rst   = cpu_rst_q;
  assign cpu_inst  = cpu_inst_q;
  assign pc_mon    = pc_mon_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_mcpu5_host_driver.sv
// Bench for mcpu5_host_driver: a small MCPU5 behavioural model answers on cpu_bus,
// OUT results are checked through a scoreboard queue drained by a monitor process.
module tb_mcpu5_host_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       run = 1'b0;
  logic       prog_we = 1'b0;
  logic [4:0] prog_addr = '0;
  logic [5:0] prog_data = '0;
  logic       cpu_clk;
  logic       cpu_rst;
  logic [5:0] cpu_inst;
  logic [7:0] cpu_bus;
  logic [7:0] pc_mon;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       overflow;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  mcpu5_host_driver #(
    .DEPTH(32),
    .HALF(2),
    .RST_CYCLES(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .run       (run),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .cpu_clk   (cpu_clk),
    .cpu_rst   (cpu_rst),
    .cpu_inst  (cpu_inst),
    .cpu_bus   (cpu_bus),
    .pc_mon    (pc_mon),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // MCPU5 model: LDI (chained LDI loads the upper nibble), STA/ADD on r0..r7,
  // BCC branches to pc+1+offset when carry is clear, else clears carry.
  logic [7:0] m_pc = '0;
  logic [7:0] m_acc = '0;
  logic [7:0] m_reg [8];
  logic       m_c = 1'b0;
  logic       m_prev_ldi = 1'b0;

  always @(posedge cpu_clk) begin
    if (cpu_rst) begin
      m_pc       <= '0;
      m_acc      <= '0;
      m_c        <= 1'b0;
      m_prev_ldi <= 1'b0;
    end else begin
      m_prev_ldi <= (cpu_inst[5:4] == 2'b01);
      m_pc       <= m_pc + 8'd1;
      case (cpu_inst[5:4])
        2'b01: m_acc <= m_prev_ldi ? {cpu_inst[3:0], m_acc[3:0]}
                                   : {{4{cpu_inst[3]}}, cpu_inst[3:0]};
        2'b10: begin
          if (cpu_inst[3]) m_reg[cpu_inst[2:0]] <= m_acc;
          else {m_c, m_acc} <= {1'b0, m_acc} + {1'b0, m_reg[cpu_inst[2:0]]};
        end
        2'b00: begin
          if (!m_c) m_pc <= m_pc + 8'd1 + {{4{cpu_inst[3]}}, cpu_inst[3:0]};
          else m_c <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign cpu_bus = cpu_clk ? m_pc : m_acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(e));
        end
      end
    end
  end

  task automatic wr(input logic [4:0] a, input logic [5:0] d);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic fill(input logic [5:0] d);
    for (int i = 0; i < 32; i++) wr(5'(i), d);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_pc(input logic [7:0] target, input int budget, input string name);
    int k = 0;
    while (pc_mon !== target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(pc_mon), 32'(target));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cpu_clk"},   32'(cpu_clk),   32'd0);
    check({tag, "_cpu_rst"},   32'(cpu_rst),   32'd1);
    check({tag, "_cpu_inst"},  32'(cpu_inst),  32'd0);
    check({tag, "_pc_mon"},    32'(pc_mon),    32'd0);
    check({tag, "_out_data"},  32'(out_data),  32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_overflow"},  32'(overflow),  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int highs;
    #12;
    check_reset_vals("rst");
    rst_n = 1'b1;

    // LDI 5; STA r0; ADD r0; OUT; BCC -1  -> OUT emits 0x0A, PC parks at 4
    fill(6'h0F);
    wr(0, 6'h15); wr(1, 6'h28); wr(2, 6'h20); wr(3, 6'h3B); wr(4, 6'h0F);
    out_ready = 1'b1;
    run = 1'b1;
    exp_q.push_back(8'h0A);
    pulse_start();
    wait_pc(8'd4, 300, "t1_pc_reach4");
    repeat (60) @(negedge clk);
    check("t1_pc_stays4", 32'(pc_mon), 32'd4);
    check("t1_one_out", 32'(exp_q.size()), 32'd0);
    check("t1_valid_drained", 32'(out_valid), 32'd0);

    // Chained LDI 5, LDI 3 -> 0x35
    do_reset();
    fill(6'h0F);
    wr(0, 6'h15); wr(1, 6'h13); wr(2, 6'h3B);
    exp_q.push_back(8'h35);
    pulse_start();
    wait_pc(8'd3, 300, "t2_pc_reach3");
    repeat (40) @(negedge clk);
    check("t2_one_out", 32'(exp_q.size()), 32'd0);

    // Two OUTs without a consumer: first value held, overflow sticks
    do_reset();
    out_ready = 1'b0;
    fill(6'h0F);
    wr(0, 6'h15); wr(1, 6'h3B); wr(2, 6'h13); wr(3, 6'h3B);
    pulse_start();
    wait_pc(8'd4, 300, "t3_pc_reach4");
    repeat (20) @(negedge clk);
    check("t3_valid_held", 32'(out_valid), 32'd1);
    check("t3_data_first", 32'(out_data), 32'h05);
    check("t3_overflow", 32'(overflow), 32'd1);
    pulse_start();
    @(negedge clk);
    check("t3_start_valid", 32'(out_valid), 32'd0);
    check("t3_start_ovf", 32'(overflow), 32'd0);
    check("t3_start_cpu_rst", 32'(cpu_rst), 32'd1);

    // NOP program wraps PC past DEPTH; a write while running is ignored
    do_reset();
    out_ready = 1'b1;
    fill(6'h3F);
    wr(0, 6'h2F);
    pulse_start();
    wait_pc(8'd2, 300, "t4_pc_reach2");
    wr(0, 6'h3F);
    wait_pc(8'd31, 400, "t4_pc_reach31");
    check("t4_inst_at31", 32'(cpu_inst), 32'h3F);
    wait_pc(8'd32, 40, "t4_pc_reach32");
    check("t4_inst_wrap_mem0", 32'(cpu_inst), 32'h2F);
    wait_pc(8'd33, 40, "t4_pc_reach33");
    check("t4_inst_at33", 32'(cpu_inst), 32'h3F);

    // Pause freezes the CPU clock and PC; memory is writable while paused
    do_reset();
    fill(6'h3F);
    pulse_start();
    wait_pc(8'd3, 300, "t5_pc_reach3");
    run = 1'b0;
    repeat (8) @(negedge clk);
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cpu_clk) highs++;
    end
    check("t5_clk_held_low", 32'(highs), 32'd0);
    check("t5_pc_frozen", 32'(pc_mon), 32'd3);
    check("t5_inst_held", 32'(cpu_inst), 32'h3F);
    wr(5, 6'h2F);
    run = 1'b1;
    wait_pc(8'd4, 40, "t5_resume_pc4");
    wait_pc(8'd5, 40, "t5_resume_pc5");
    check("t5_paused_write", 32'(cpu_inst), 32'h2F);

    // Asynchronous reset mid-run
    wait_pc(8'd7, 40, "t6_pc_reach7");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("t6");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
